cgram_font_reader: RTL and testbench
====================================

Name: cgram_font_reader

Overview:
- Reads the custom-font glyphs back out of the text LCD's CGRAM over the parallel LCD bus (RW=1 data reads) and checks each row against an expected-font source.
- It is the read/verify counterpart of the CGRAM font loading path. It runs after font load and before normal display traffic, and reports a per-byte stream, a mismatch count, the first bad address and a pass flag.
- It generates its own E strobe, so each bus transaction is a fixed 4-clock frame.

Parameters:
- NUM_CHARS, 5, number of 5x8 glyphs to read back, starting at CGRAM char 0; legal range 1..8.
- ROWS, 8, rows per glyph. Fixed at 8 for the 5x8 font.

Ports:
- CLK  in  1  system clock
- RESETN  in  1  reset, asynchronous, active-high
- START  in  1  one-cycle request to begin a readback; honoured only in IDLE
- TLCD_E  out  1  LCD enable strobe
- TLCD_RS  out  1  register select: 0 = command, 1 = data
- TLCD_RW  out  1  0 = write, 1 = read
- TLCD_DATA_OUT  out  8  bus value when driving
- TLCD_DATA_OE  out  1  1 = block drives the bus; 0 = bus released for LCD reads
- TLCD_DATA_IN  in  8  bus value sampled during reads
- EXP_ADDR  out  6  byte index (char*8+row) of the expected-font lookup
- EXP_DATA  in  8  expected byte for EXP_ADDR; combinational source, valid same cycle
- RD_VALID  out  1  one-cycle pulse per byte read
- RD_ADDR  out  6  byte index of RD_DATA
- RD_DATA  out  8  byte read from CGRAM
- MISMATCH_CNT  out  6  number of mismatching rows; saturates at 63
- FIRST_BAD_ADDR  out  6  index of the first mismatching byte; 63 when none
- BUSY  out  1  high from START acceptance until DONE
- DONE  out  1  high after the last read; held until the next accepted START or reset
- PASS  out  1  DONE with MISMATCH_CNT==0

Behaviour:
- Reset values (RESETN high, asynchronous):
  - State IDLE; phase counter 0.
  - TLCD_E=0, TLCD_RS=0, TLCD_RW=0, TLCD_DATA_OUT=0x00, TLCD_DATA_OE=0.
  - RD_VALID=0, RD_ADDR=0, RD_DATA=0.
  - MISMATCH_CNT=0, FIRST_BAD_ADDR=63, BUSY=0, DONE=0, PASS=0.
- States: IDLE, SET_ADDR, READ_ROW, FINISH.
- Every SET_ADDR or READ_ROW visit is a 4-clock bus frame, driven by a 2-bit phase counter:
  - phase 0: E=0; RS/RW/DATA_OUT/OE set up.
  - phase 1: E=1.
  - phase 2: E=1; on a read, TLCD_DATA_IN is registered on the edge that ends phase 2.
  - phase 3: E=0; RS/RW held.
  - RS, RW, OE and DATA_OUT stay constant across all four phases.
- IDLE:
  - START=1 moves to SET_ADDR with char=0, row=0.
  - It also clears MISMATCH_CNT, FIRST_BAD_ADDR (to 63), DONE and PASS, and sets BUSY=1.
- SET_ADDR:
  - RS=0, RW=0, OE=1, DATA_OUT = 0x40 | (char<<3).
  - At the end of phase 3, go to READ_ROW.
- READ_ROW:
  - RS=1, RW=1, OE=0. The LCD auto-increments its address, so there are no per-row address writes.
  - In phase 3: RD_VALID=1 for exactly this cycle, RD_ADDR = char*8+row, RD_DATA = sampled byte. EXP_ADDR equals that index.
  - Compare only bits [4:0] of the sampled byte against EXP_DATA[4:0]; bits [7:5] are ignored.
  - On mismatch: MISMATCH_CNT increments (saturating). FIRST_BAD_ADDR loads RD_ADDR only if it still holds 63.
  - At the end of phase 3:
    - row<7: row+1, stay in READ_ROW.
    - row==7 and char<NUM_CHARS-1: row=0, char+1, go to SET_ADDR.
    - otherwise: go to FINISH.
- FINISH (one cycle): DONE=1, PASS=(MISMATCH_CNT==0), BUSY=0, then IDLE. DONE and PASS hold.
- Latency:
  - First phase-0 outputs are valid after the edge that samples START.
  - Total frames = NUM_CHARS*9; DONE rises NUM_CHARS*36+1 clocks after that edge (181 for the default).
- Boundary conditions:
  - START while BUSY: ignored, no effect.
  - START in the same cycle DONE rises: ignored.
  - Reset mid-frame: E drops to 0 immediately and the bus is released (OE=0); the next run needs a new START.
  - EXP_ADDR is 0 while IDLE.
  - RD_ADDR maximum is NUM_CHARS*8-1 (≤63).

Decomposition:
- Shared LCD package holds:
  - LCD command constants (CMD_SET_CGRAM=0x40, CMD_SET_DDRAM=0x80).
  - State encoding localparams (IDLE/SET_ADDR/READ_ROW/FINISH).
  - Bus phase constants.
  - Glyph geometry (ROWS=8, GLYPH_BITS=5).
- Sub-module lcd_bus_phaser: 4-phase counter producing E, a frame-start strobe, a sample strobe (end of phase 2) and a frame-end strobe. It is reusable by the font loader and the display writer.

Test Plan:
- Clean pass:
  - Stimulus: START, with an LCD model returning the 40-byte expected font (char 0 rows 0x06,0x07,0x04,0x06,0x0C,0x1C,0x1C,0x14, ...).
  - Required: 40 RD_VALID pulses with RD_ADDR 0..39 in order; command bytes 0x40, 0x48, 0x50, 0x58, 0x60 with OE=1; DONE at clock 181; PASS=1; MISMATCH_CNT=0; FIRST_BAD_ADDR=63.
- Single corruption:
  - Stimulus: model returns 0x0F at byte 19 (expected 0x0E).
  - Required: MISMATCH_CNT=1, FIRST_BAD_ADDR=19, PASS=0, DONE=1.
- Upper bits ignored:
  - Stimulus: model returns 0xE6 at byte 0 (expected 0x06) and 0xFF-masked values elsewhere.
  - Required: MISMATCH_CNT=0, PASS=1; RD_DATA at byte 0 reads back 0xE6.
- Bus timing:
  - Stimulus: check every frame.
  - Required: E = 0,1,1,0 over 4 clocks; RS/RW/OE stable across the frame; OE=0 and RW=1 in every read frame; sampled value equals TLCD_DATA_IN at the end of phase 2.
- Reset and restart:
  - Stimulus: RESETN asserted during phase 1 of a read at byte 12, then released.
  - Required: E=0, OE=0, BUSY=0, DONE=0 immediately. A fresh START then completes the full 40-byte run with PASS=1.
- START while busy:
  - Stimulus: START pulses at clocks 50 and 100 of a run.
  - Required: no restart; byte order unchanged; DONE still at clock 181.

Source files
------------

// File: rtl/cgram_font_reader_pkg.sv
// Shared text-LCD definitions: command bytes, FSM encoding, bus phases and glyph geometry.
package cgram_font_reader_pkg;
    localparam logic [7:0] CMD_SET_CGRAM = 8'h40;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SET_ADDR = 2'd1;
    localparam logic [1:0] ST_READ_ROW = 2'd2;
    localparam logic [1:0] ST_FINISH   = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        SET_ADDR = ST_SET_ADDR,
        READ_ROW = ST_READ_ROW,
        FINISH   = ST_FINISH
    } state_t;

    localparam logic [1:0] PH_SETUP  = 2'd0;
    localparam logic [1:0] PH_E_RISE = 2'd1;
    localparam logic [1:0] PH_SAMPLE = 2'd2;
    localparam logic [1:0] PH_HOLD   = 2'd3;

    localparam int         ROWS        = 8;
    localparam int         GLYPH_BITS  = 5;
    localparam logic [7:0] GLYPH_MASK  = 8'((1 << GLYPH_BITS) - 1);
    localparam logic [5:0] NO_BAD_ADDR = 6'd63;

    // Set-CGRAM-address command pointing at row 0 of a glyph.
    function automatic logic [7:0] cgram_cmd(input logic [2:0] ch);
        return CMD_SET_CGRAM | {2'b00, ch, 3'b000};
    endfunction
endpackage

// File: rtl/cgram_font_reader_if.sv
// Parallel text-LCD bus; master is the controller, slave is the LCD.
interface cgram_font_reader_if;
    logic       TLCD_E;
    logic       TLCD_RS;
    logic       TLCD_RW;
    logic [7:0] TLCD_DATA_OUT;
    logic       TLCD_DATA_OE;
    logic [7:0] TLCD_DATA_IN;

    modport master (
        output TLCD_E, TLCD_RS, TLCD_RW, TLCD_DATA_OUT, TLCD_DATA_OE,
        input  TLCD_DATA_IN
    );
    modport slave (
        input  TLCD_E, TLCD_RS, TLCD_RW, TLCD_DATA_OUT, TLCD_DATA_OE,
        output TLCD_DATA_IN
    );
endinterface

// File: rtl/cgram_font_reader_lcd_bus_phaser.sv
// Four-clock LCD bus frame generator: registered E strobe plus sample/frame-end strobes.
module lcd_bus_phaser
    import cgram_font_reader_pkg::*;
(
    input  logic CLK,
    input  logic RESETN,
    input  logic run,
    output logic e,
    output logic sample,
    output logic frame_end
);
    logic [1:0] phase;
    logic       frame_start;

    assign frame_start = run && (phase == PH_SETUP);
    assign sample      = run && (phase == PH_SAMPLE);
    assign frame_end   = run && (phase == PH_HOLD);

    // E is registered so it is high exactly while the counter sits in phases 1 and 2.
    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            phase <= PH_SETUP;
            e     <= 1'b0;
        end else begin
            phase <= run ? phase + 2'd1 : PH_SETUP;
            e     <= frame_start || (run && (phase == PH_E_RISE));
        end
    end
endmodule

// File: rtl/cgram_font_reader.sv
// Reads the custom glyphs back out of CGRAM and checks each row's 5 pixel bits against a reference font.
module cgram_font_reader #(
    parameter int NUM_CHARS = 5,
    parameter int ROWS      = 8
) (
    input  logic                        CLK,
    input  logic                        RESETN,
    input  logic                        START,
    cgram_font_reader_if.master         lcd,
    output logic [5:0]                  EXP_ADDR,
    input  logic [7:0]                  EXP_DATA,
    output logic                        RD_VALID,
    output logic [5:0]                  RD_ADDR,
    output logic [7:0]                  RD_DATA,
    output logic [5:0]                  MISMATCH_CNT,
    output logic [5:0]                  FIRST_BAD_ADDR,
    output logic                        BUSY,
    output logic                        DONE,
    output logic                        PASS
);
    import cgram_font_reader_pkg::*;

    localparam logic [2:0] LAST_CHAR = 3'(NUM_CHARS - 1);
    localparam logic [2:0] LAST_ROW  = 3'(ROWS - 1);

    state_t     state;
    logic [2:0] char_idx;
    logic [2:0] row;
    logic       rs_q, rw_q, oe_q;
    logic [7:0] dout_q;
    logic       run, e, sample, frame_end;
    logic       row_bad;

    assign run = (state == SET_ADDR) || (state == READ_ROW);

    lcd_bus_phaser u_phaser (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .run       (run),
        .e         (e),
        .sample    (sample),
        .frame_end (frame_end)
    );

    assign lcd.TLCD_E        = e;
    assign lcd.TLCD_RS       = rs_q;
    assign lcd.TLCD_RW       = rw_q;
    assign lcd.TLCD_DATA_OUT = dout_q;
    assign lcd.TLCD_DATA_OE  = oe_q;

    // During phase 3 of a read frame EXP_ADDR equals RD_ADDR, so EXP_DATA lines up with RD_DATA.
    assign EXP_ADDR = (state == IDLE) ? 6'd0 : {char_idx, row};
    assign row_bad  = ((RD_DATA ^ EXP_DATA) & GLYPH_MASK) != 8'h00;

    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            state          <= IDLE;
            char_idx       <= '0;
            row            <= '0;
            rs_q           <= 1'b0;
            rw_q           <= 1'b0;
            oe_q           <= 1'b0;
            dout_q         <= 8'h00;
            RD_VALID       <= 1'b0;
            RD_ADDR        <= '0;
            RD_DATA        <= 8'h00;
            MISMATCH_CNT   <= '0;
            FIRST_BAD_ADDR <= NO_BAD_ADDR;
            BUSY           <= 1'b0;
            DONE           <= 1'b0;
            PASS           <= 1'b0;
        end else begin
            RD_VALID <= 1'b0;
            case (state)
                IDLE: if (START) begin
                    state          <= SET_ADDR;
                    char_idx       <= '0;
                    row            <= '0;
                    rs_q           <= 1'b0;
                    rw_q           <= 1'b0;
                    oe_q           <= 1'b1;
                    dout_q         <= cgram_cmd(3'd0);
                    MISMATCH_CNT   <= '0;
                    FIRST_BAD_ADDR <= NO_BAD_ADDR;
                    BUSY           <= 1'b1;
                    DONE           <= 1'b0;
                    PASS           <= 1'b0;
                end
                SET_ADDR: if (frame_end) begin
                    state <= READ_ROW;
                    rs_q  <= 1'b1;
                    rw_q  <= 1'b1;
                    oe_q  <= 1'b0;
                end
                READ_ROW: begin
                    if (sample) begin
                        RD_VALID <= 1'b1;
                        RD_ADDR  <= {char_idx, row};
                        RD_DATA  <= lcd.TLCD_DATA_IN;
                    end
                    if (frame_end) begin
                        if (row_bad) begin
                            if (MISMATCH_CNT != 6'd63)
                                MISMATCH_CNT <= MISMATCH_CNT + 6'd1;
                            if (FIRST_BAD_ADDR == NO_BAD_ADDR)
                                FIRST_BAD_ADDR <= RD_ADDR;
                        end
                        // LCD auto-increments within CGRAM; only glyph boundaries get a fresh address write.
                        if (row != LAST_ROW) begin
                            row <= row + 3'd1;
                        end else if (char_idx != LAST_CHAR) begin
                            row      <= '0;
                            char_idx <= char_idx + 3'd1;
                            state    <= SET_ADDR;
                            rs_q     <= 1'b0;
                            rw_q     <= 1'b0;
                            oe_q     <= 1'b1;
                            dout_q   <= cgram_cmd(char_idx + 3'd1);
                        end else begin
                            state  <= FINISH;
                            rs_q   <= 1'b0;
                            rw_q   <= 1'b0;
                            oe_q   <= 1'b0;
                            dout_q <= 8'h00;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    DONE  <= 1'b1;
                    PASS  <= (MISMATCH_CNT == 6'd0);
                    BUSY  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cgram_font_reader.sv
// Directed bench: an LCD CGRAM model plus a cycle-indexed frame model checked every clock.
module tb_cgram_font_reader;
    localparam int NB = 40;

    logic       CLK = 1'b0;
    logic       RESETN;
    logic       START;
    logic [5:0] EXP_ADDR;
    logic [7:0] EXP_DATA;
    logic       RD_VALID;
    logic [5:0] RD_ADDR;
    logic [7:0] RD_DATA;
    logic [5:0] MISMATCH_CNT;
    logic [5:0] FIRST_BAD_ADDR;
    logic       BUSY, DONE, PASS;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] font     [64];
    logic [7:0] lcd_mem  [64];
    logic [5:0] lcd_ptr = 6'd0;
    logic [7:0] rd0;
    int         cmd_seen [5];

    cgram_font_reader_if lcd ();

    cgram_font_reader #(.NUM_CHARS(5), .ROWS(8)) dut (
        .CLK            (CLK),
        .RESETN         (RESETN),
        .START          (START),
        .lcd            (lcd),
        .EXP_ADDR       (EXP_ADDR),
        .EXP_DATA       (EXP_DATA),
        .RD_VALID       (RD_VALID),
        .RD_ADDR        (RD_ADDR),
        .RD_DATA        (RD_DATA),
        .MISMATCH_CNT   (MISMATCH_CNT),
        .FIRST_BAD_ADDR (FIRST_BAD_ADDR),
        .BUSY           (BUSY),
        .DONE           (DONE),
        .PASS           (PASS)
    );

    always #5 CLK = ~CLK;

    assign EXP_DATA         = font[EXP_ADDR];
    assign lcd.TLCD_DATA_IN = lcd_mem[lcd_ptr];

    // HD44780-style address counter: set-CGRAM writes load it, data reads bump it.
    always @(negedge lcd.TLCD_E) begin
        if (lcd.TLCD_RS === 1'b0 && lcd.TLCD_RW === 1'b0)
            lcd_ptr <= lcd.TLCD_DATA_OUT[5:0];
        else if (lcd.TLCD_RS === 1'b1 && lcd.TLCD_RW === 1'b1)
            lcd_ptr <= lcd_ptr + 6'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle c counts from the clock edge that accepted START; frame f = c/4, phase = c%4,
    // and every ninth frame is the set-address frame for glyph f/9.
    task automatic run_check(input bit busy_starts, input int reset_at, output int pulses);
        int f, ph, idx, exp_cnt, exp_first, ncmd;
        logic [7:0] din_ph2;
        exp_cnt = 0; exp_first = 63; pulses = 0; ncmd = 0; din_ph2 = 8'h00;
        for (int i = 0; i < NB; i++)
            if (((lcd_mem[i] ^ font[i]) & 8'h1F) != 8'h00) begin
                exp_cnt++;
                if (exp_first == 63) exp_first = i;
            end
        @(negedge CLK) START = 1'b1;
        @(negedge CLK) START = 1'b0;
        for (int c = 0; c <= 182; c++) begin
            f = c / 4; ph = c % 4;
            if (c == reset_at) begin
                RESETN = 1'b1;
                #1;
                chk("rst_E", lcd.TLCD_E, 0);
                chk("rst_OE", lcd.TLCD_DATA_OE, 0);
                chk("rst_BUSY", BUSY, 0);
                chk("rst_DONE", DONE, 0);
                repeat (3) @(negedge CLK);
                RESETN = 1'b0;
                return;
            end
            if (c < 180) begin
                chk("E", lcd.TLCD_E, (ph == 1 || ph == 2));
                if (f % 9 == 0) begin
                    chk("cmd_RS", lcd.TLCD_RS, 0);
                    chk("cmd_RW", lcd.TLCD_RW, 0);
                    chk("cmd_OE", lcd.TLCD_DATA_OE, 1);
                    chk("cmd_DATA", lcd.TLCD_DATA_OUT, 8'h40 | ((f / 9) << 3));
                    if (ph == 0 && ncmd < 5) begin
                        cmd_seen[ncmd] = lcd.TLCD_DATA_OUT;
                        ncmd++;
                    end
                end else begin
                    chk("rd_RS", lcd.TLCD_RS, 1);
                    chk("rd_RW", lcd.TLCD_RW, 1);
                    chk("rd_OE", lcd.TLCD_DATA_OE, 0);
                    if (ph == 2) din_ph2 = lcd.TLCD_DATA_IN;
                end
                chk("BUSY_run", BUSY, 1);
                chk("DONE_run", DONE, 0);
                chk("RD_VALID", RD_VALID, (f % 9 != 0 && ph == 3));
                if (RD_VALID === 1'b1) pulses++;
                if (f % 9 != 0 && ph == 3) begin
                    idx = (f / 9) * 8 + (f % 9) - 1;
                    chk("RD_ADDR", RD_ADDR, idx);
                    chk("EXP_ADDR", EXP_ADDR, idx);
                    chk("RD_DATA", RD_DATA, lcd_mem[idx]);
                    chk("RD_DATA_ph2", RD_DATA, din_ph2);
                    if (idx == 0) rd0 = RD_DATA;
                end
            end else if (c == 180) begin
                chk("fin_BUSY", BUSY, 1);
                chk("fin_DONE", DONE, 0);
                chk("fin_E", lcd.TLCD_E, 0);
            end else begin
                chk("DONE", DONE, 1);
                chk("BUSY_done", BUSY, 0);
                chk("PASS", PASS, exp_cnt == 0);
                chk("MISMATCH_CNT", MISMATCH_CNT, exp_cnt);
                chk("FIRST_BAD_ADDR", FIRST_BAD_ADDR, exp_first);
                chk("idle_OE", lcd.TLCD_DATA_OE, 0);
                chk("idle_EXP_ADDR", EXP_ADDR, 0);
            end
            if (busy_starts) START = (c == 50 || c == 100 || c == 180);
            @(negedge CLK);
        end
        START = 1'b0;
    endtask

    initial begin
        logic [7:0] font_init [NB] = '{
            8'h06, 8'h07, 8'h04, 8'h06, 8'h0C, 8'h1C, 8'h1C, 8'h14,
            8'h00, 8'h0A, 8'h1F, 8'h1F, 8'h0E, 8'h04, 8'h00, 8'h00,
            8'h04, 8'h0E, 8'h15, 8'h0E, 8'h04, 8'h04, 8'h0A, 8'h11,
            8'h1F, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h1F,
            8'h00, 8'h1B, 8'h1B, 8'h00, 8'h11, 8'h0E, 8'h00, 8'h00};
        int cmd_lit [5] = '{'h40, 'h48, 'h50, 'h58, 'h60};
        int p;
        for (int i = 0; i < 64; i++) font[i] = (i < NB) ? font_init[i] : 8'h00;
        for (int i = 0; i < 64; i++) lcd_mem[i] = font[i];
        rd0 = 8'h00;
        RESETN = 1'b1;
        START  = 1'b0;
        repeat (3) @(negedge CLK);

        chk("reset_E", lcd.TLCD_E, 0);
        chk("reset_RS", lcd.TLCD_RS, 0);
        chk("reset_RW", lcd.TLCD_RW, 0);
        chk("reset_DATA_OUT", lcd.TLCD_DATA_OUT, 0);
        chk("reset_OE", lcd.TLCD_DATA_OE, 0);
        chk("reset_RD_VALID", RD_VALID, 0);
        chk("reset_RD_ADDR", RD_ADDR, 0);
        chk("reset_RD_DATA", RD_DATA, 0);
        chk("reset_MISMATCH_CNT", MISMATCH_CNT, 0);
        chk("reset_FIRST_BAD", FIRST_BAD_ADDR, 63);
        chk("reset_BUSY", BUSY, 0);
        chk("reset_DONE", DONE, 0);
        chk("reset_PASS", PASS, 0);
        chk("reset_EXP_ADDR", EXP_ADDR, 0);
        RESETN = 1'b0;
        repeat (2) @(negedge CLK);

        // Clean pass
        run_check(1'b0, -1, p);
        chk("clean_pulses", p, 40);
        for (int k = 0; k < 5; k++) chk("clean_cmd_byte", cmd_seen[k], cmd_lit[k]);
        chk("clean_PASS", PASS, 1);
        chk("clean_MISMATCH_CNT", MISMATCH_CNT, 0);
        chk("clean_FIRST_BAD", FIRST_BAD_ADDR, 63);

        // Single corrupted row
        lcd_mem[19] = 8'h0F;
        run_check(1'b0, -1, p);
        chk("corrupt_MISMATCH_CNT", MISMATCH_CNT, 1);
        chk("corrupt_FIRST_BAD", FIRST_BAD_ADDR, 19);
        chk("corrupt_PASS", PASS, 0);
        chk("corrupt_DONE", DONE, 1);

        // Bits [7:5] must be ignored by the compare
        for (int i = 0; i < 64; i++) lcd_mem[i] = font[i] | 8'hE0;
        run_check(1'b0, -1, p);
        chk("upper_MISMATCH_CNT", MISMATCH_CNT, 0);
        chk("upper_PASS", PASS, 1);
        chk("upper_rd0", rd0, 8'hE6);

        // Reset during phase 1 of the read of byte 12 (frame 14 -> cycle 57), then a fresh run
        for (int i = 0; i < 64; i++) lcd_mem[i] = font[i];
        run_check(1'b0, 57, p);
        repeat (3) @(negedge CLK);
        chk("post_rst_BUSY", BUSY, 0);
        chk("post_rst_DONE", DONE, 0);
        chk("post_rst_E", lcd.TLCD_E, 0);
        chk("post_rst_OE", lcd.TLCD_DATA_OE, 0);
        run_check(1'b0, -1, p);
        chk("restart_pulses", p, 40);
        chk("restart_PASS", PASS, 1);

        // START pulses while busy and in the FINISH cycle are ignored
        run_check(1'b1, -1, p);
        chk("busy_start_pulses", p, 40);
        chk("busy_start_PASS", PASS, 1);
        repeat (2) @(negedge CLK);
        chk("busy_start_idle", BUSY, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
